mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the DLX pipeline; consumes the EX-stage outputs (ALU result, store operand, instruction, memory enable) and performs LW/SW on data memory.
- Talks to data memory through a req/ack handshake with variable latency.
- Stalls upstream while an access is pending.
- Registers results for write-back.

Parameters:
ADDR_W, 16, data-memory address width; dmem_addr = alu_in4[ADDR_W-1:0]
TIMEOUT, 64, max BUSY cycles without ack before abort (used only with the optional feature)

Ports:
clock4  input  1  stage clock, rising edge
reset4  input  1  asynchronous active-low reset
alu_in4  input  32  EX ALU result / effective address
bin4  input  32  EX store operand
inst_in4  input  32  EX instruction register
mem_en4  input  1  EX memory-access enable
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write (SW), 0 = read (LW)
dmem_addr  output  ADDR_W  memory address
dmem_wdata  output  32  store data
dmem_ack  input  1  memory completion, single-cycle pulse
dmem_rdata  input  32  read data, valid when dmem_ack=1
stall4  output  1  upstream must hold its inputs while high
valid4  output  1  one-cycle pulse per retired non-bubble instruction
alu_out4  output  32  registered ALU result to WB
lmd_out4  output  32  load memory data to WB
inst_out4  output  32  instruction to WB
err4  output  1  access aborted; tied 0 without the optional feature

Behaviour:
- Reset (asynchronous, active-low). All outputs are 0; state is IDLE; the timeout counter is 0. Reset mid-access drops dmem_req immediately and abandons the access.
- Opcode is inst_in4[31:26]. LW=6'b000101, SW=6'b001010. Instruction 32'h0 is a bubble.
- FSM states: IDLE and BUSY.
- IDLE, every edge:
  - inst_out4 <= inst_in4; alu_out4 <= alu_in4.
  - If opcode is LW or SW and mem_en4=1: dmem_req <= 1; dmem_we <= (SW); dmem_addr <= alu_in4[ADDR_W-1:0]; dmem_wdata <= bin4 for SW (held otherwise); stall4 <= 1; valid4 <= 0; go to BUSY.
  - Else: valid4 <= (inst_in4 != 0). lmd_out4 is unchanged.
  - LW/SW with mem_en4=0 performs no access and retires as a pass-through.
- BUSY:
  - Hold dmem_req, dmem_we, dmem_addr, dmem_wdata, inst_out4, alu_out4 stable; valid4=0.
  - On an edge with dmem_ack=1: dmem_req <= 0; stall4 <= 0; valid4 <= 1; for LW, lmd_out4 <= dmem_rdata; go to IDLE.
- Timing:
  - Minimum memory-op latency: inputs sampled at edge N; dmem_req high from N; earliest ack sampled at N+1; valid4 high after N+1.
  - Non-memory ops: 1-cycle latency, with valid4 in the cycle after sampling.
- Upstream contract: holds inst_in4, alu_in4, bin4, mem_en4 while stall4=1. The stage does not sample them in BUSY. Its first IDLE sample is the next instruction.
- dmem_ack while IDLE (spurious) is ignored and has no effect.
- Back-to-back memory ops: the cycle after ack retires is IDLE and may immediately launch the next request; there is no dead cycle beyond that.
- Arithmetic: none. Address truncation drops alu_in4[31:ADDR_W].

Optional Feature:
MEM_ACCESS_TIMEOUT_EN
- Defined:
  - A counter increments each BUSY cycle and clears on entering BUSY.
  - If it reaches TIMEOUT with no ack: dmem_req <= 0; stall4 <= 0; valid4 <= 1; err4 <= 1 for that single cycle; for LW, lmd_out4 <= 0; go to IDLE.
  - Ack on the same edge as the timeout wins, i.e. a normal completion with err4=0.
- Not defined: no counter; BUSY waits indefinitely; err4 is constant 0.

Decomposition:
- Shared package dlx_pkg holds:
  - opcode constants LW, SW, BEQZ, BNEZ, J, R_TYPE;
  - function codes;
  - the bubble constant 32'h0;
  - the FSM state encoding (IDLE=1'b0, BUSY=1'b1).
- One natural sub-module, dmem_handshake: request/ack FSM plus the optional timeout counter. The top level does opcode decode and the WB registers.

Test Plan:
- Reset then ADDI pass-through: inst 0x40000000-class ADDI, alu_in4=0x25 -> next cycle valid4=1, alu_out4=0x25, stall4=0, dmem_req=0.
- LW, alu_in4=0x0010, memory acks after 3 cycles with rdata=0xCAFEF00D -> dmem_req/stall4 high 3 cycles, we=0, addr=0x0010, then valid4=1, lmd_out4=0xCAFEF00D.
- SW, alu_in4=0x0020, bin4=0x12345678, ack in first BUSY cycle -> we=1, wdata=0x12345678, valid4 pulses once, lmd_out4 unchanged.
- Back-to-back LW then SW, plus a spurious ack in IDLE -> two requests, no extra retire, correct order in inst_out4.
- Reset deasserted-then-asserted mid-LW (BUSY) -> dmem_req, stall4, valid4 drop to 0 asynchronously; after release a fresh LW completes normally.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT=4, no ack -> after 4 BUSY cycles err4=1 and valid4=1 for one cycle, lmd_out4=0; ack arriving on cycle 4 -> err4=0.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, function codes, bubble word, MEM-stage FSM encoding.
// Latency: n/a (constants and a pure decode helper).
// Backpressure: n/a.
package dlx_pkg;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] BEQZ   = 6'b000100;
    localparam logic [5:0] LW     = 6'b000101;
    localparam logic [5:0] BNEZ   = 6'b000110;
    localparam logic [5:0] SW     = 6'b001010;
    localparam logic [5:0] ADDI   = 6'b010000;

    // R-type function codes, inst[5:0]
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // An all-zero instruction word is a pipeline bubble.
    localparam logic [31:0] BUBBLE = 32'h0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bundle between the MEM stage (master) and data memory (slave).
// Latency: n/a (wires only).
// Backpressure: req is held until a single-cycle ack; rdata is valid only with ack.
// Ports: dmem_req, dmem_we, dmem_addr, dmem_wdata (master->slave); dmem_ack, dmem_rdata (slave->master).
interface mem_access_stage_if #(
    parameter int ADDR_W = 16
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage_dmem_handshake.sv
// Request/ack FSM for data memory, with an optional BUSY timeout (macro MEM_ACCESS_TIMEOUT_EN).
// Latency: req rises the edge after start; done is combinational on the edge that ack (or timeout) is seen.
// Backpressure: busy stays high from launch until ack/timeout; start is ignored while busy.
// Ports: clk/rst_n, start + start_we/addr/wdata (launch), dmem (master modport), busy, done, timed_out.
module dmem_handshake
    import dlx_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [31:0]       start_wdata,
    mem_access_stage_if.master dmem,
    output logic              busy,
    output logic              done,
    output logic              timed_out
);

    state_t            state, state_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (dmem.dmem_ack || timed_out) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request attributes are captured once at launch and held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && start) begin
            we_q   <= start_we;
            addr_q <= start_addr;
            if (start_we) begin
                wdata_q <= start_wdata;
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] busy_cnt;

    // Held at zero in IDLE so every access starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (state == IDLE) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th BUSY edge; a coincident ack takes precedence.
    assign timed_out = (state == BUSY) && !dmem.dmem_ack
                       && (busy_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timed_out      = 1'b0;
`endif

    assign busy            = (state == BUSY);
    assign dmem.dmem_req   = (state == BUSY);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// DLX MEM stage: decodes LW/SW, runs the data-memory handshake, registers results for WB.
// Latency: non-memory ops retire 1 cycle after sampling; memory ops retire the edge after ack (min 2 edges).
// Backpressure: stall4 is high while an access is pending; inputs are not sampled then.
// Ports: clock4/reset4, EX inputs (alu_in4, bin4, inst_in4, mem_en4), dmem (master modport),
//        stall4, WB outputs (valid4, alu_out4, lmd_out4, inst_out4), err4.
// Optional: MEM_ACCESS_TIMEOUT_EN enables the BUSY timeout abort; otherwise err4 is always 0.
module mem_access_stage
    import dlx_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic        clock4,
    input  logic        reset4,
    input  logic [31:0] alu_in4,
    input  logic [31:0] bin4,
    input  logic [31:0] inst_in4,
    input  logic        mem_en4,
    mem_access_stage_if.master dmem,
    output logic        stall4,
    output logic        valid4,
    output logic [31:0] alu_out4,
    output logic [31:0] lmd_out4,
    output logic [31:0] inst_out4,
    output logic        err4
);

    logic [5:0] opcode;
    logic       is_lw;
    logic       is_sw;
    logic       launch;
    logic       busy;
    logic       done;
    logic       timed_out;

    assign opcode = opcode_of(inst_in4);
    assign is_lw  = (opcode == LW);
    assign is_sw  = (opcode == SW);
    // LW/SW with mem_en4 low are plain pass-throughs.
    assign launch = !busy && mem_en4 && (is_lw || is_sw);

    dmem_handshake #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_handshake (
        .clk         (clock4),
        .rst_n       (reset4),
        .start       (launch),
        .start_we    (is_sw),
        .start_addr  (alu_in4[ADDR_W-1:0]),
        .start_wdata (bin4),
        .dmem        (dmem),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out)
    );

    assign stall4 = busy;

    always_ff @(posedge clock4 or negedge reset4) begin
        if (!reset4) begin
            valid4    <= 1'b0;
            alu_out4  <= '0;
            lmd_out4  <= '0;
            inst_out4 <= '0;
            err4      <= 1'b0;
        end else if (!busy) begin
            inst_out4 <= inst_in4;
            alu_out4  <= alu_in4;
            valid4    <= !launch && (inst_in4 != BUBBLE);
            err4      <= 1'b0;
        end else begin
            // inst/alu stay frozen on the in-flight instruction until it retires.
            valid4 <= done;
            err4   <= timed_out;
            if (done && !dmem.dmem_we) begin
                lmd_out4 <= timed_out ? 32'h0 : dmem.dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a variable-latency memory responder.
// Latency: n/a. Backpressure: upstream driver holds inputs while stall4 is high.
// Ports: none (top-level bench).
module tb_mem_access_stage;
    import dlx_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_in4, bin4, inst_in4;
    logic        mem_en4;
    logic        stall4, valid4, err4;
    logic [31:0] alu_out4, lmd_out4, inst_out4;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_W(ADDR_W)) dmem_bus ();

    mem_access_stage #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock4    (clk),
        .reset4    (rst_n),
        .alu_in4   (alu_in4),
        .bin4      (bin4),
        .inst_in4  (inst_in4),
        .mem_en4   (mem_en4),
        .dmem      (dmem_bus),
        .stall4    (stall4),
        .valid4    (valid4),
        .alu_out4  (alu_out4),
        .lmd_out4  (lmd_out4),
        .inst_out4 (inst_out4),
        .err4      (err4)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic        err;
    } retire_t;

    retire_t     exp_q[$];
    retire_t     e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_lmd = 32'h0;
    int          mem_lat = 0;
    logic [31:0] mem_rdata = 32'h0;
    bit          spur_req = 1'b0;
    int          lat_cnt = 0;
    bit          exp_timeout = 1'b0;
    int          launches = 0;
    logic        prev_req = 1'b0;
    int          n;
    int          l0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Drive one instruction at a negedge once the stage is not stalled; returns at the
    // negedge after the sampling edge with the inputs still held.
    task automatic send(input logic [31:0] inst, input logic [31:0] alu,
                        input logic [31:0] b, input logic en);
        int      guard = 0;
        retire_t r;
        logic    mem_op;
        while (stall4 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (stall4) check("stall_release", {31'd0, stall4}, 32'd0);
        inst_in4 = inst;
        alu_in4  = alu;
        bin4     = b;
        mem_en4  = en;
        mem_op   = en && (inst[31:26] == LW || inst[31:26] == SW);
        if (en && inst[31:26] == LW) model_lmd = exp_timeout ? 32'h0 : mem_rdata;
        if (inst != 32'h0) begin
            r.inst = inst;
            r.alu  = alu;
            r.lmd  = model_lmd;
            r.err  = mem_op && exp_timeout;
            exp_q.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic count_req(output int cnt);
        cnt = 0;
        while (dmem_bus.dmem_req && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Memory responder: ack in the mem_lat-th cycle of a request (mem_lat=0: never).
    initial begin
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            dmem_bus.dmem_ack = 1'b0;
            if (!rst_n || !dmem_bus.dmem_req) begin
                lat_cnt = 0;
                if (spur_req && rst_n) begin
                    dmem_bus.dmem_ack   = 1'b1;
                    dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
                    spur_req            = 1'b0;
                end
            end else if (mem_lat > 0) begin
                lat_cnt++;
                if (lat_cnt == mem_lat) begin
                    dmem_bus.dmem_ack   = 1'b1;
                    dmem_bus.dmem_rdata = mem_rdata;
                    lat_cnt             = 0;
                end
            end
        end
    end

    // Retire monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (dmem_bus.dmem_req && !prev_req) launches++;
            prev_req = dmem_bus.dmem_req;
            if (valid4) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ret_inst", inst_out4, e.inst);
                    check("ret_alu", alu_out4, e.alu);
                    check("ret_lmd", lmd_out4, e.lmd);
                    check("ret_err", {31'd0, err4}, {31'd0, e.err});
                end else begin
                    check("unexpected_retire", {31'd0, valid4}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        inst_in4 = 32'h0;
        alu_in4  = 32'h0;
        bin4     = 32'h0;
        mem_en4  = 1'b0;
        #12;
        check("rst_valid", {31'd0, valid4}, 32'd0);
        check("rst_stall", {31'd0, stall4}, 32'd0);
        check("rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
        check("rst_addr", {16'd0, dmem_bus.dmem_addr}, 32'd0);
        check("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
        check("rst_alu", alu_out4, 32'd0);
        check("rst_lmd", lmd_out4, 32'd0);
        check("rst_inst", inst_out4, 32'd0);
        check("rst_err", {31'd0, err4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI pass-through
        send(mk(ADDI, 16'h0025), 32'h25, 32'h0, 1'b0);
        check("addi_stall", {31'd0, stall4}, 32'd0);
        check("addi_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

        // LW, ack after 3 cycles
        mem_lat   = 3;
        mem_rdata = 32'hCAFE_F00D;
        send(mk(LW, 16'h0010), 32'h0000_0010, 32'h0, 1'b1);
        check("lw_stall", {31'd0, stall4}, 32'd1);
        check("lw_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
        check("lw_addr", {16'd0, dmem_bus.dmem_addr}, 32'h10);
        count_req(n);
        check("lw_req_cycles", n, 32'd3);

        // SW, ack in first BUSY cycle; rdata on the bus must not reach lmd
        mem_lat   = 1;
        mem_rdata = 32'hBAD0_BAD0;
        send(mk(SW, 16'h0020), 32'h0000_0020, 32'h1234_5678, 1'b1);
        check("sw_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        check("sw_wdata", dmem_bus.dmem_wdata, 32'h1234_5678);
        check("sw_addr", {16'd0, dmem_bus.dmem_addr}, 32'h20);
        count_req(n);
        check("sw_req_cycles", n, 32'd1);

        // LW with mem_en4 low: no access, pass-through retire
        l0 = launches;
        send(mk(LW, 16'h0070), 32'h0000_0070, 32'h0, 1'b0);
        check("lw_noen_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

        // Back-to-back LW then SW; upper address bits must be truncated
        mem_lat   = 2;
        mem_rdata = 32'hA5A5_5A5A;
        send(mk(LW, 16'h0030), 32'hFFFF_0030, 32'h0, 1'b1);
        check("b2b_lw_addr", {16'd0, dmem_bus.dmem_addr}, 32'h0030);
        send(mk(SW, 16'h0044), 32'h0000_0044, 32'hDEAD_BEEF, 1'b1);
        check("b2b_sw_wdata", dmem_bus.dmem_wdata, 32'hDEAD_BEEF);
        send(32'h0, 32'h0, 32'h0, 1'b0);
        check("b2b_launches", launches - l0, 32'd2);

        // Spurious ack while idle
        l0       = launches;
        spur_req = 1'b1;
        send(32'h0, 32'h0, 32'h0, 1'b0);
        send(32'h0, 32'h0, 32'h0, 1'b0);
        send(32'h0, 32'h0, 32'h0, 1'b0);
        check("spur_lmd", lmd_out4, model_lmd);
        check("spur_stall", {31'd0, stall4}, 32'd0);
        check("spur_launches", launches - l0, 32'd0);

        // Reset in the middle of a LW
        mem_lat = 0;
        send(mk(LW, 16'h0050), 32'h0000_0050, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall4}, 32'd0);
        check("mid_rst_valid", {31'd0, valid4}, 32'd0);
        check("mid_rst_lmd", lmd_out4, 32'd0);
        exp_q.delete();
        model_lmd = 32'h0;
        inst_in4  = 32'h0;
        alu_in4   = 32'h0;
        mem_en4   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_lat   = 2;
        mem_rdata = 32'h0BAD_CAFE;
        send(mk(LW, 16'h0054), 32'h0000_0054, 32'h0, 1'b1);
        count_req(n);
        check("post_rst_req_cycles", n, 32'd2);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack: abort after TIMEOUT BUSY cycles
        mem_lat     = 0;
        exp_timeout = 1'b1;
        send(mk(LW, 16'h0060), 32'h0000_0060, 32'h0, 1'b1);
        exp_timeout = 1'b0;
        count_req(n);
        check("to_req_cycles", n, TIMEOUT);
        // Ack on the timeout edge completes normally
        mem_lat   = TIMEOUT;
        mem_rdata = 32'h7777_1234;
        send(mk(LW, 16'h0064), 32'h0000_0064, 32'h0, 1'b1);
        count_req(n);
        check("to_ack_req_cycles", n, TIMEOUT);
`else
        // Without the timeout, BUSY waits as long as memory takes
        mem_lat   = 0;
        mem_rdata = 32'h7777_1234;
        send(mk(LW, 16'h0060), 32'h0000_0060, 32'h0, 1'b1);
        repeat (20) @(negedge clk);
        check("wait_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
        check("wait_stall", {31'd0, stall4}, 32'd1);
        mem_lat = 1;
        count_req(n);
        check("wait_req_tail", n, 32'd2);
`endif

        send(32'h0, 32'h0, 32'h0, 1'b0);
        send(32'h0, 32'h0, 32'h0, 1'b0);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
